// File: rtl/isa_pkg.sv
// Shared ISA constants, opcodes and fetch FSM encoding.
// Imported by the fetch front end and its instruction store.
package isa_pkg;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    localparam logic [31:0] NOP_WORD = 32'hF800_0000;
    localparam logic [31:0] END_WORD = 32'hFFFF_FFFF;

    localparam logic [4:0] OP_ADDI = 5'd1;
    localparam logic [4:0] OP_J    = 5'd16;
    localparam logic [4:0] OP_NOP  = 5'd31;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t HALT = 2'd2;

    function automatic logic [4:0] opcode(input logic [31:0] w);
        return w[31:27];
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction store: one synchronous write port, one async read.
// Contents survive reset so a loaded program can be re-run.
module imem_array #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // program-load write, no reset on the storage
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC, Instruct register, run/halt FSM, issue count.
// Next address comes back from decode on NEWPC each cycle.
import isa_pkg::*;

module instruction_fetch_unit #(
    parameter int DEPTH  = isa_pkg::DEPTH,
    parameter int ADDR_W = isa_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              start,
    input  logic              stall,
    input  logic [31:0]       NEWPC,
    output logic [31:0]       Instruct,
    output logic [31:0]       Pc,
    output logic              running,
    output logic              halted,
    output logic              fault,
    output logic [31:0]       fetch_cnt
);

    state_t            state;
    logic              wr_en;
    logic              in_range;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic [31:0]       start_word;

    // loads are only accepted while the fetch loop is stopped
    assign wr_en    = load_en && (state != RUN);
    assign in_range = NEWPC < 32'(DEPTH);
    assign rd_addr  = (state == RUN) ? NEWPC[ADDR_W-1:0] : '0;

    // a load to word 0 on the start edge must be seen by that fetch
    assign start_word = (wr_en && load_addr == '0) ? load_data : rd_data;

    imem_array #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_imem (
        .clk  (clk),
        .we   (wr_en),
        .waddr(load_addr),
        .wdata(load_data),
        .raddr(rd_addr),
        .rdata(rd_data)
    );

    // fetch FSM with PC, instruction and issue-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            Instruct  <= NOP_WORD;
            Pc        <= '0;
            fault     <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state     <= RUN;
                        Pc        <= '0;
                        Instruct  <= start_word;
                        fetch_cnt <= 32'd1;
                        fault     <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (Instruct == END_WORD) begin
                            state    <= HALT;
                            Instruct <= NOP_WORD;
                        end else if (!in_range) begin
                            state    <= HALT;
                            fault    <= 1'b1;
                            Instruct <= NOP_WORD;
                            Pc       <= NEWPC;
                        end else begin
                            Pc        <= NEWPC;
                            Instruct  <= rd_data;
                            fetch_cnt <= fetch_cnt + 32'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    Instruct <= NOP_WORD;
                end
            endcase
        end
    end

    assign running = (state == RUN);
    assign halted  = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small decode model.
// Decode returns Pc+1, the J target, or a forced address.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        stall;
    logic [31:0] newpc;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        running;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_cnt;

    logic        force_en;
    logic [31:0] force_val;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_en  (load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .start    (start),
        .stall    (stall),
        .NEWPC    (newpc),
        .Instruct (instr),
        .Pc       (pc),
        .running  (running),
        .halted   (halted),
        .fault    (fault),
        .fetch_cnt(fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // decode model: J (opcode 16) jumps to low 27 bits, else Pc+1
    always_comb begin
        newpc = pc + 32'd1;
        if (instr[31:27] == 5'd16) begin
            newpc = {5'd0, instr[26:0]};
        end
        if (force_en) begin
            newpc = force_val;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [4:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        step();
        load_en = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_instr"}, instr, 32'hF800_0000);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_run"}, {31'd0, running}, 32'd0);
        chk({tag, "_halt"}, {31'd0, halted}, 32'd0);
        chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
        chk({tag, "_cnt"}, fetch_cnt, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        start     = 1'b0;
        stall     = 1'b0;
        force_en  = 1'b0;
        force_val = '0;

        // reset then idle
        #12;
        chk_reset("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_instr", instr, 32'hF800_0000);
            chk("idle_pc", pc, 32'd0);
            chk("idle_run", {31'd0, running}, 32'd0);
        end

        // straight-line program
        load(5'd0, 32'h0800_0000);
        load(5'd1, 32'h0800_0001);
        load(5'd2, 32'h0800_0002);
        load(5'd3, 32'hFFFF_FFFF);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("sl_pc0", pc, 32'd0);
        chk("sl_i0", instr, 32'h0800_0000);
        chk("sl_cnt0", fetch_cnt, 32'd1);
        chk("sl_run", {31'd0, running}, 32'd1);
        step();
        chk("sl_pc1", pc, 32'd1);
        chk("sl_i1", instr, 32'h0800_0001);
        step();
        chk("sl_pc2", pc, 32'd2);
        step();
        chk("sl_pc3", pc, 32'd3);
        chk("sl_end", instr, 32'hFFFF_FFFF);
        chk("sl_cnt3", fetch_cnt, 32'd4);
        step();
        chk("sl_nop", instr, 32'hF800_0000);
        chk("sl_halt", {31'd0, halted}, 32'd1);
        chk("sl_cnt", fetch_cnt, 32'd4);
        chk("sl_pchold", pc, 32'd3);

        // jump
        load(5'd1, 32'h8000_0012);
        load(5'd18, 32'hFFFF_FFFF);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("j_pc0", pc, 32'd0);
        step();
        chk("j_pc1", pc, 32'd1);
        chk("j_i1", instr, 32'h8000_0012);
        step();
        chk("j_pc18", pc, 32'd18);
        chk("j_end", instr, 32'hFFFF_FFFF);
        chk("j_cnt", fetch_cnt, 32'd3);
        step();
        chk("j_halt", {31'd0, halted}, 32'd1);
        chk("j_nop", instr, 32'hF800_0000);

        // load+start on word 0, then stall with dropped load/start
        load(5'd1, 32'h0800_0001);
        load_en   = 1'b1;
        load_addr = 5'd0;
        load_data = 32'h0800_00AA;
        start     = 1'b1;
        step();
        load_en = 1'b0;
        start   = 1'b0;
        chk("ls_pc", pc, 32'd0);
        chk("ls_i0", instr, 32'h0800_00AA);
        step();
        step();
        chk("st_pc2", pc, 32'd2);
        chk("st_cnt2", fetch_cnt, 32'd3);
        stall     = 1'b1;
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 5'd3;
        load_data = 32'h0800_0003;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_pc", pc, 32'd2);
            chk("st_i", instr, 32'h0800_0002);
            chk("st_cnt", fetch_cnt, 32'd3);
        end
        stall   = 1'b0;
        start   = 1'b0;
        load_en = 1'b0;
        step();
        chk("st_pc3", pc, 32'd3);
        chk("st_memkeep", instr, 32'hFFFF_FFFF);
        chk("st_cnt4", fetch_cnt, 32'd4);
        step();
        chk("st_halt", {31'd0, halted}, 32'd1);

        // fault on out-of-range NEWPC
        start = 1'b1;
        step();
        start = 1'b0;
        force_en  = 1'b1;
        force_val = 32'd40;
        step();
        force_en = 1'b0;
        chk("f_fault", {31'd0, fault}, 32'd1);
        chk("f_halt", {31'd0, halted}, 32'd1);
        chk("f_nop", instr, 32'hF800_0000);
        chk("f_pc", pc, 32'd40);
        chk("f_cnt", fetch_cnt, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("f_clr", {31'd0, fault}, 32'd0);
        chk("f_pc0", pc, 32'd0);
        chk("f_run", {31'd0, running}, 32'd1);
        force_en  = 1'b1;
        force_val = 32'h0001_0002;
        step();
        force_en = 1'b0;
        chk("fu_fault", {31'd0, fault}, 32'd1);
        chk("fu_pc", pc, 32'h0001_0002);

        // async reset mid-run at Pc=5
        for (int i = 3; i < 8; i++) begin
            load(5'(i), 32'h0800_0000 + 32'(i));
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        chk("mr_pc5", pc, 32'd5);
        chk("mr_cnt", fetch_cnt, 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mr");
        step();
        chk_reset("mrh");
        rst_n = 1'b1;
        step();
        chk_reset("mri");

        // memory survives reset
        start = 1'b1;
        step();
        start = 1'b0;
        chk("keep_i0", instr, 32'h0800_00AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
